iram_loader: RTL and testbench
==============================

# iram_loader

Serial program loader for the 16-bit single-cycle CPU's 128-entry instruction memory. It takes a byte stream from the receive side of the host link, frames and checksums it, and writes 16-bit instruction words into the instruction memory's write port. It holds the CPU in reset until a complete, verified image is in place. It sits between the byte receiver and the instruction memory, alongside the CPU's reset logic.

## Interface
- DEPTH, 128: number of instruction words; word address width is 7.
- TIMEOUT, 65535: maximum idle clock cycles between bytes inside a frame.
- HDR, 8'hA5: frame start byte.

- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-low reset.
- RX_DATA  in  8  received byte.
- RX_VALID  in  1  one-cycle strobe; RX_DATA is valid in this cycle. There is no backpressure: every strobe is consumed.
- WE  out  1  instruction-memory write strobe, one cycle.
- WADDR  out  7  word address for WE.
- WDATA  out  16  instruction word for WE.
- CPU_HOLD  out  1  high while the CPU must stay in reset.
- DONE  out  1  high after a verified load.
- ERR  out  1  high after a failed load; sticky.

## Operation
- States: IDLE, COUNT, HI, LO, CSUM, LOADED, FAIL.
- Reset (RESET low, asynchronous):
  - State goes to IDLE.
  - WE=0, WADDR=0, WDATA=0, CPU_HOLD=1, DONE=0, ERR=0.
  - Internal sum=0, word counter=0, timeout counter=0.
- IDLE:
  - A byte equal to HDR moves to COUNT and clears the sum.
  - Any other byte is ignored.
- COUNT:
  - Byte N is the word count. The sum becomes N.
  - N=0 or N>DEPTH: go to FAIL.
  - Otherwise latch N, set the write address to 0, and go to HI.
- HI:
  - The byte is stored as the high byte of the word and added to the sum. Go to LO.
- LO:
  - The byte is added to the sum.
  - {hi,byte} is registered onto WDATA and the current address onto WADDR. WE pulses.
  - Then the address increments and the remaining count decrements.
  - Remaining count reaches 0: go to CSUM. Otherwise go to HI.
- CSUM:
  - (sum + byte) mod 256 == 0: go to LOADED. Otherwise go to FAIL.
- LOADED:
  - DONE=1, CPU_HOLD=0, ERR=0.
- FAIL:
  - ERR=1, CPU_HOLD=1, DONE=0.
- Arithmetic:
  - The sum is 8-bit and wraps modulo 256.
  - The word address is 7-bit.
  - The count register must hold the value 128 (8 bits).
- Reload:
  - In LOADED or FAIL, a byte equal to HDR clears DONE and ERR, sets CPU_HOLD=1, and goes to COUNT.
  - Other bytes in LOADED or FAIL are ignored.
- HDR inside a frame (in COUNT, HI, LO or CSUM) is ordinary data. There is no resynchronisation.
- Words already written before a FAIL are not rolled back. CPU_HOLD stays high, so the CPU never runs a partial image.
- Timeout:
  - In COUNT, HI, LO or CSUM, the timeout counter increments on every cycle without RX_VALID and clears on RX_VALID.
  - Reaching TIMEOUT moves to FAIL.
  - The counter does not run in IDLE, LOADED or FAIL.
- Reset mid-frame aborts immediately: no WE is issued and CPU_HOLD stays high.

## Timing
- All outputs are registered.
- A byte strobed in cycle t changes state at edge t+1.
- WE is high for exactly the cycle after the LO-byte strobe, with WADDR and WDATA valid in that same cycle.
- WADDR and WDATA hold their values until the next write.
- DONE rises and CPU_HOLD falls in the cycle after the CSUM-byte strobe.
- ERR rises in the cycle after the offending strobe, or in the cycle after the timeout count reaches TIMEOUT.
- Back-to-back RX_VALID on consecutive cycles is supported at full rate. Minimum frame time is 2N+3 cycles.
- WE never fires in two consecutive cycles. The minimum gap between writes is 2 cycles.

## Test plan
- Nominal load:
  - Stimulus: A5 02 F0 01 F4 91 88, one byte per cycle.
  - Required: WE at addr 0 with data F001, then at addr 1 with data F491. DONE=1, CPU_HOLD=0, ERR=0.
- Bad checksum:
  - Stimulus: same frame with last byte 89.
  - Required: both writes occur, then ERR=1, DONE=0, CPU_HOLD=1.
- Invalid count:
  - Stimulus: A5 00, then separately A5 81.
  - Required: FAIL after the count byte with no WE. A following full valid frame recovers to DONE=1.
- Timeout (TIMEOUT=16):
  - Stimulus: A5 01 F0, then 16 idle cycles.
  - Required: ERR=1 and no WE.
  - Also, a 15-cycle gap followed by 01 and checksum 0E still completes with DONE=1.
- Reset mid-frame:
  - Stimulus: RESET low, asynchronously, between the HI and LO bytes.
  - Required: outputs immediately take their reset values and no WE is issued. A fresh valid frame loads correctly.
- Reload and max size:
  - Stimulus: after DONE, send a 128-word frame with words 0..127 and the correct checksum.
  - Required: CPU_HOLD=1 from the header onward, 128 writes with WADDR wrapping exactly to 127, then DONE=1.

Source files
------------

// File: rtl/iram_loader_if.sv
// Byte-receive and instruction-memory write signals of the program loader.
// The loader is the slave; the host side or bench is the master.
interface iram_loader_if #(
  parameter int unsigned AW = 7
);
  logic [7:0]    RX_DATA;
  logic          RX_VALID;
  logic          WE;
  logic [AW-1:0] WADDR;
  logic [15:0]   WDATA;
  logic          CPU_HOLD;
  logic          DONE;
  logic          ERR;

  modport slave (
    input  RX_DATA, RX_VALID,
    output WE, WADDR, WDATA, CPU_HOLD, DONE, ERR
  );

  modport master (
    output RX_DATA, RX_VALID,
    input  WE, WADDR, WDATA, CPU_HOLD, DONE, ERR
  );
endinterface

// File: rtl/iram_loader.sv
// Serial program loader: frames a byte stream, writes 16-bit words into the
// instruction memory and holds the CPU in reset until a checksummed image is in place.
module iram_loader #(
  parameter int unsigned DEPTH   = 128,
  parameter int unsigned TIMEOUT = 65535,
  parameter logic [7:0]  HDR     = 8'hA5
) (
  input logic          CLK,
  input logic          RESET,
  iram_loader_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StCount, StHi, StLo, StCsum, StLoaded, StFail} state_e;

  state_e        state_q, state_d;
  logic [7:0]    sum_q, sum_d;
  logic [7:0]    rem_q, rem_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    hi_q, hi_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic          hold_q, hold_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          in_frame;
  logic [7:0]    sum_add;

  always_comb begin
    state_d  = state_q;
    sum_d    = sum_q;
    rem_d    = rem_q;
    addr_d   = addr_q;
    hi_d     = hi_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    in_frame = (state_q == StCount) || (state_q == StHi) ||
               (state_q == StLo) || (state_q == StCsum);
    sum_add  = sum_q + bus.RX_DATA;

    // Idle gap counter only runs while a frame is open.
    if (!in_frame || bus.RX_VALID) begin
      tcnt_d = '0;
    end else begin
      tcnt_d = tcnt_q + TW'(1);
    end

    if (in_frame && (tcnt_q == TW'(TIMEOUT))) begin
      state_d = StFail;
      tcnt_d  = '0;
    end else if (bus.RX_VALID) begin
      unique case (state_q)
        StIdle, StLoaded, StFail: begin
          if (bus.RX_DATA == HDR) begin
            state_d = StCount;
            sum_d   = 8'd0;
          end
        end
        StCount: begin
          sum_d = bus.RX_DATA;
          if ((bus.RX_DATA == 8'd0) || ({24'd0, bus.RX_DATA} > DEPTH)) begin
            state_d = StFail;
          end else begin
            rem_d   = bus.RX_DATA;
            addr_d  = '0;
            state_d = StHi;
          end
        end
        StHi: begin
          hi_d    = bus.RX_DATA;
          sum_d   = sum_add;
          state_d = StLo;
        end
        StLo: begin
          sum_d   = sum_add;
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = {hi_q, bus.RX_DATA};
          addr_d  = addr_q + AW'(1);
          rem_d   = rem_q - 8'd1;
          state_d = (rem_q == 8'd1) ? StCsum : StHi;
        end
        StCsum: begin
          state_d = (sum_add == 8'd0) ? StLoaded : StFail;
        end
        default: state_d = StIdle;
      endcase
    end

    // Status flags follow the next state so they change on the same edge.
    hold_d = (state_d != StLoaded);
    done_d = (state_d == StLoaded);
    err_d  = (state_d == StFail);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q <= StIdle;
      sum_q   <= 8'd0;
      rem_q   <= 8'd0;
      addr_q  <= '0;
      hi_q    <= 8'd0;
      tcnt_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= 16'd0;
      hold_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      rem_q   <= rem_d;
      addr_q  <= addr_d;
      hi_q    <= hi_d;
      tcnt_q  <= tcnt_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.WE       = we_q;
  assign bus.WADDR    = waddr_q;
  assign bus.WDATA    = wdata_q;
  assign bus.CPU_HOLD = hold_q;
  assign bus.DONE     = done_q;
  assign bus.ERR      = err_q;
endmodule

// File: tb/tb_iram_loader.sv
// Directed bench for iram_loader: nominal, bad checksum, bad count, timeout,
// mid-frame reset and full 128-word reload.
module tb_iram_loader;
  logic CLK;
  logic RESET;
  int   errors = 0;
  int   checks = 0;

  iram_loader_if #(.AW(7)) bus ();

  iram_loader #(
    .DEPTH  (128),
    .TIMEOUT(16),
    .HDR    (8'hA5)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Write log: every WE cycle is captured, plus back-to-back WE occurrences.
  logic [6:0]  wa[$];
  logic [15:0] wd[$];
  int          consec  = 0;
  logic        we_prev = 1'b0;
  always @(negedge CLK) begin
    if (bus.WE) begin
      wa.push_back(bus.WADDR);
      wd.push_back(bus.WDATA);
      if (we_prev) consec++;
    end
    we_prev = bus.WE;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [7:0] b);
    bus.RX_DATA  = b;
    bus.RX_VALID = 1'b1;
    @(negedge CLK);
    bus.RX_VALID = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    bus.RX_DATA  = 8'h00;
    bus.RX_VALID = 1'b0;
    RESET        = 1'b0;
    idle(2);
    check("rst_hold",  32'(bus.CPU_HOLD), 32'd1);
    check("rst_done",  32'(bus.DONE),     32'd0);
    check("rst_err",   32'(bus.ERR),      32'd0);
    check("rst_we",    32'(bus.WE),       32'd0);
    check("rst_waddr", 32'(bus.WADDR),    32'd0);
    check("rst_wdata", 32'(bus.WDATA),    32'd0);
    RESET = 1'b1;
    idle(2);

    // Nominal load, one byte per cycle
    clear_log();
    drive(8'hA5); drive(8'h02); drive(8'hF0); drive(8'h01);
    check("nom_we0",    32'(bus.WE),    32'd1);
    check("nom_waddr0", 32'(bus.WADDR), 32'd0);
    check("nom_wdata0", 32'(bus.WDATA), 32'hF001);
    drive(8'hF4);
    check("nom_we_gap", 32'(bus.WE),    32'd0);
    check("nom_hold_mid", 32'(bus.CPU_HOLD), 32'd1);
    drive(8'h91);
    check("nom_we1",    32'(bus.WE),    32'd1);
    check("nom_waddr1", 32'(bus.WADDR), 32'd1);
    check("nom_wdata1", 32'(bus.WDATA), 32'hF491);
    drive(8'h88);
    check("nom_done", 32'(bus.DONE),     32'd1);
    check("nom_hold", 32'(bus.CPU_HOLD), 32'd0);
    check("nom_err",  32'(bus.ERR),      32'd0);
    idle(2);
    check("nom_nwr",  32'(wa.size()),    32'd2);
    check("nom_wdata_hold", 32'(bus.WDATA), 32'hF491);

    // Bad checksum, reloaded from LOADED
    clear_log();
    drive(8'hA5);
    check("bad_hold_hdr", 32'(bus.CPU_HOLD), 32'd1);
    check("bad_done_hdr", 32'(bus.DONE),     32'd0);
    drive(8'h02); drive(8'hF0); drive(8'h01); drive(8'hF4); drive(8'h91); drive(8'h89);
    check("bad_err",  32'(bus.ERR),      32'd1);
    check("bad_done", 32'(bus.DONE),     32'd0);
    check("bad_hold", 32'(bus.CPU_HOLD), 32'd1);
    idle(2);
    check("bad_nwr",  32'(wa.size()),    32'd2);
    check("bad_err_sticky", 32'(bus.ERR), 32'd1);

    // Invalid counts 0 and 129
    clear_log();
    drive(8'hA5);
    check("cnt_err_clr", 32'(bus.ERR), 32'd0);
    drive(8'h00);
    check("cnt0_err", 32'(bus.ERR), 32'd1);
    drive(8'hA5); drive(8'h81);
    check("cnt81_err", 32'(bus.ERR), 32'd1);
    idle(2);
    check("cnt_nwr", 32'(wa.size()), 32'd0);
    drive(8'hA5); drive(8'h02); drive(8'hF0); drive(8'h01);
    drive(8'hF4); drive(8'h91); drive(8'h88);
    check("cnt_recover_done", 32'(bus.DONE), 32'd1);
    check("cnt_recover_err",  32'(bus.ERR),  32'd0);
    idle(2);

    // Timeout after the HI byte
    clear_log();
    drive(8'hA5); drive(8'h01); drive(8'hF0);
    idle(20);
    check("to_err",  32'(bus.ERR),      32'd1);
    check("to_hold", 32'(bus.CPU_HOLD), 32'd1);
    check("to_nwr",  32'(wa.size()),    32'd0);
    // A 15-cycle gap is still inside the limit
    drive(8'hA5); drive(8'h01); drive(8'hF0);
    idle(15);
    drive(8'h01); drive(8'h0E);
    check("gap15_done", 32'(bus.DONE), 32'd1);
    idle(2);
    check("gap15_nwr",   32'(wa.size()), 32'd1);
    check("gap15_wdata", 32'(wd[0]),     32'hF001);

    // Asynchronous reset between the HI and LO bytes
    clear_log();
    drive(8'hA5); drive(8'h01); drive(8'hF0);
    #2 RESET = 1'b0;
    #1;
    check("mrst_hold",  32'(bus.CPU_HOLD), 32'd1);
    check("mrst_done",  32'(bus.DONE),     32'd0);
    check("mrst_wdata", 32'(bus.WDATA),    32'd0);
    check("mrst_we",    32'(bus.WE),       32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    idle(2);
    check("mrst_nwr", 32'(wa.size()), 32'd0);
    drive(8'hA5); drive(8'h01); drive(8'h12); drive(8'h34); drive(8'hB9);
    check("mrst_fresh_done", 32'(bus.DONE),  32'd1);
    check("mrst_fresh_data", 32'(bus.WDATA), 32'h1234);
    idle(2);

    // Full 128-word reload: words 0..127, checksum C0
    clear_log();
    drive(8'hA5);
    check("max_hold_hdr", 32'(bus.CPU_HOLD), 32'd1);
    drive(8'h80);
    for (int i = 0; i < 128; i++) begin
      drive(8'h00);
      drive(8'(i));
    end
    check("max_hold_pre", 32'(bus.CPU_HOLD), 32'd1);
    drive(8'hC0);
    check("max_done", 32'(bus.DONE),     32'd1);
    check("max_hold", 32'(bus.CPU_HOLD), 32'd0);
    idle(2);
    check("max_nwr", 32'(wa.size()), 32'd128);
    bad = 0;
    for (int i = 0; i < wa.size(); i++) begin
      if (wa[i] !== 7'(i) || wd[i] !== 16'(i)) bad++;
    end
    check("max_seq_bad", 32'(bad), 32'd0);
    if (wa.size() == 128) check("max_last_addr", 32'(wa[127]), 32'd127);
    check("we_consec", 32'(consec), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
